// File: rtl/omsp_sm_viol_log.sv
// Logs SM violation events {cause, SM id, pc} into a FIFO readable over the openMSP430 peripheral bus.
// Push is visible one cycle after the event; the level irq follows one cycle later. SM_VIOL_RESET_EN adds the reset-request pulse.
module omsp_sm_viol_log #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [13:0] BASE_ADDR  = 14'h0190
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        violation,
    input  logic        dma_violation,
    input  logic [15:0] spm_current_id,
    input  logic [15:0] pc,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic        viol_irq,
    output logic        viol_reset_req
);
    localparam int          PW     = $clog2(FIFO_DEPTH);
    localparam logic [3:0]  DEPTH4 = 4'(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0]  cause;
        logic [15:0] id;
        logic [15:0] pc;
    } rec_t;

    rec_t          mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [3:0]    count;
    logic          overflow, irq_en, reset_en;
    logic [7:0]    drop_cnt;
    logic          violation_d, dma_violation_d;

    logic          ev_cpu, ev_dma, ev;
    logic          not_empty, full;
    logic [13:0]   offset;
    logic          reg_wr, rd_en, pop_cmd, clr_cmd;
    logic          do_push, do_pop, drop;
    rec_t          head;

    assign ev_cpu    = violation & ~violation_d;
    assign ev_dma    = dma_violation & ~dma_violation_d;
    assign ev        = ev_cpu | ev_dma;
    assign not_empty = (count != 4'd0);
    assign full      = (count == DEPTH4);

    // Modular subtraction makes a single compare cover the whole window.
    assign offset  = per_addr - BASE_ADDR;
    assign reg_wr  = per_en & (per_we != 2'b00) & (offset == 14'd1);
    assign rd_en   = per_en & (per_we == 2'b00) & (offset < 14'd5);
    assign pop_cmd = reg_wr & per_we[1] & per_din[8];
    assign clr_cmd = reg_wr & per_we[1] & per_din[9];

    // A pop from a full FIFO frees the slot the same-cycle event needs.
    assign do_pop  = pop_cmd & not_empty;
    assign do_push = ev & (~full | do_pop);
    assign drop    = ev & full & ~do_pop;

    assign head = not_empty ? mem[rd_ptr] : '0;

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= 4'd0;
            overflow        <= 1'b0;
            drop_cnt        <= 8'd0;
            irq_en          <= 1'b0;
            violation_d     <= 1'b0;
            dma_violation_d <= 1'b0;
            viol_irq        <= 1'b0;
        end else begin
            violation_d     <= violation;
            dma_violation_d <= dma_violation;
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (clr_cmd) begin
                overflow <= 1'b0;
                drop_cnt <= 8'd0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end
            if (reg_wr & per_we[0])
                irq_en <= per_din[0];
            viol_irq <= irq_en & not_empty;
        end
    end

    always_ff @(posedge mclk) begin
        if (!puc_rst && do_push)
            mem[wr_ptr] <= '{cause: {ev_dma, ev_cpu}, id: spm_current_id, pc: pc};
    end

`ifdef SM_VIOL_RESET_EN
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            reset_en       <= 1'b0;
            viol_reset_req <= 1'b0;
        end else begin
            if (reg_wr & per_we[0])
                reset_en <= per_din[1];
            viol_reset_req <= ev & reset_en;
        end
    end
    logic unused_din;
    assign unused_din = ^{per_din[15:10], per_din[7:2]};
`else
    assign reset_en       = 1'b0;
    assign viol_reset_req = 1'b0;
    logic unused_din;
    assign unused_din = ^{per_din[15:10], per_din[7:1]};
`endif

    always_comb begin
        per_dout = 16'h0000;
        if (rd_en) begin
            case (offset[2:0])
                3'd0:    per_dout = {drop_cnt, 1'b0, count, overflow, full, not_empty};
                3'd1:    per_dout = {14'd0, reset_en, irq_en};
                3'd2:    per_dout = head.id;
                3'd3:    per_dout = head.pc;
                3'd4:    per_dout = {14'd0, head.cause};
                default: per_dout = 16'h0000;
            endcase
        end
    end
endmodule

// File: tb/tb_omsp_sm_viol_log.sv
// Scoreboard bench for omsp_sm_viol_log: the driver queues expected values, a negedge monitor compares.
module tb_omsp_sm_viol_log;
    localparam logic [13:0] BASE = 14'h0190;

    logic        mclk, puc_rst, violation, dma_violation;
    logic [15:0] spm_current_id, pc, per_din, per_dout;
    logic [13:0] per_addr;
    logic        per_en, viol_irq, viol_reset_req;
    logic [1:0]  per_we;

    logic        chk_vld;
    logic [15:0] exp_q[$];
    int          kind_q[$];
    string       name_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] ctrl_full_exp, rst_req_exp;

    omsp_sm_viol_log #(.FIFO_DEPTH(4), .BASE_ADDR(14'h0190)) dut (
        .mclk(mclk), .puc_rst(puc_rst), .violation(violation), .dma_violation(dma_violation),
        .spm_current_id(spm_current_id), .pc(pc), .per_addr(per_addr), .per_din(per_din),
        .per_en(per_en), .per_we(per_we), .per_dout(per_dout), .viol_irq(viol_irq),
        .viol_reset_req(viol_reset_req)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Monitor: consumes one expectation per cycle in which the driver flags an observation.
    always @(negedge mclk) begin
        if (chk_vld) begin
            logic [15:0] e, act;
            int          k;
            string       nm;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL monitor_underflow: observation with no expectation queued");
            end else begin
                e  = exp_q.pop_front();
                k  = kind_q.pop_front();
                nm = name_q.pop_front();
                act = (k == 0) ? per_dout : (k == 1) ? {15'd0, viol_irq} : {15'd0, viol_reset_req};
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", nm, act, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge mclk);
        #1;
        per_en   = 1'b0;
        per_we   = 2'b00;
        per_din  = 16'h0000;
        per_addr = 14'h0000;
        chk_vld  = 1'b0;
    endtask

    // Flags the current cycle for observation: kind 0 = per_dout, 1 = viol_irq, 2 = viol_reset_req.
    task automatic expect_now(input int kind, input logic [15:0] e, input string nm);
        exp_q.push_back(e);
        kind_q.push_back(kind);
        name_q.push_back(nm);
        chk_vld = 1'b1;
    endtask

    task automatic rd(input int off, input logic [15:0] e, input string nm);
        step();
        per_en   = 1'b1;
        per_addr = BASE + 14'(off);
        expect_now(0, e, nm);
    endtask

    task automatic wr(input int off, input logic [15:0] d, input logic [1:0] we);
        step();
        per_en   = 1'b1;
        per_we   = we;
        per_addr = BASE + 14'(off);
        per_din  = d;
    endtask

    task automatic pop();
        wr(1, 16'h0100, 2'b10);
    endtask

    task automatic pulse_cpu(input logic [15:0] id, input logic [15:0] p);
        step();
        violation      = 1'b1;
        spm_current_id = id;
        pc             = p;
        step();
        violation      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef SM_VIOL_RESET_EN
        ctrl_full_exp = 16'h0003;
        rst_req_exp   = 16'h0001;
`else
        ctrl_full_exp = 16'h0001;
        rst_req_exp   = 16'h0000;
`endif
        puc_rst = 1'b1; violation = 1'b0; dma_violation = 1'b0;
        spm_current_id = 16'h0000; pc = 16'h0000;
        per_en = 1'b0; per_we = 2'b00; per_din = 16'h0000; per_addr = 14'h0000; chk_vld = 1'b0;
        repeat (3) step();
        puc_rst = 1'b0;

        // Reset state
        rd(0, 16'h0000, "rst_stat");
        rd(1, 16'h0000, "rst_ctrl");
        rd(2, 16'h0000, "rst_head_id");
        rd(3, 16'h0000, "rst_head_pc");
        rd(4, 16'h0000, "rst_head_cause");
        step(); expect_now(1, 16'h0000, "rst_irq");
        step(); expect_now(2, 16'h0000, "rst_reset_req");

        // Held-high violation logs a single record
        wr(1, 16'h0001, 2'b01);
        step(); violation = 1'b1; spm_current_id = 16'h0002; pc = 16'hE010;
        step(); step(); step(); violation = 1'b0;
        rd(2, 16'h0002, "held_head_id");
        rd(3, 16'hE010, "held_head_pc");
        rd(4, 16'h0001, "held_head_cause");
        rd(0, 16'h0009, "held_stat");
        step(); expect_now(1, 16'h0001, "held_irq");
        rd(1, 16'h0001, "ctrl_irq_en");
        pop();
        step();
        rd(0, 16'h0000, "pop_stat");
        step(); expect_now(1, 16'h0000, "pop_irq");

        // Simultaneous CPU and DMA rise
        step(); violation = 1'b1; dma_violation = 1'b1; spm_current_id = 16'h0003;
        step(); violation = 1'b0; dma_violation = 1'b0;
        rd(4, 16'h0003, "both_cause");
        rd(2, 16'h0003, "both_id");
        rd(0, 16'h0009, "both_stat");
        pop();

        // Six events into a depth-4 FIFO
        for (int i = 0; i < 6; i++)
            pulse_cpu(16'h0010 + 16'(i), 16'hF000 + 16'(i));
        rd(0, 16'h0227, "ovf_stat");
        rd(2, 16'h0010, "ovf_head_id");
        rd(3, 16'hF000, "ovf_head_pc");
        wr(1, 16'h0200, 2'b10);
        rd(0, 16'h0023, "clr_ovf_stat");
        step(); expect_now(1, 16'h0001, "full_irq");

        // Full FIFO: pop and event together
        pop();
        violation = 1'b1; spm_current_id = 16'h0020; pc = 16'hF0AA;
        step(); violation = 1'b0;
        rd(0, 16'h0023, "full_popush_stat");
        rd(2, 16'h0011, "full_popush_head");
        repeat (3) pop();
        rd(2, 16'h0020, "tail_rec_id");
        rd(3, 16'hF0AA, "tail_rec_pc");
        rd(0, 16'h0009, "tail_rec_stat");
        pop();
        rd(0, 16'h0000, "drained_stat");

        // Empty FIFO: pop and event together
        pop();
        violation = 1'b1; spm_current_id = 16'h0030; pc = 16'h1234;
        step(); violation = 1'b0;
        rd(0, 16'h0009, "empty_popush_stat");
        rd(2, 16'h0030, "empty_popush_id");
        pop();

        // Reset-request pulse (optional feature)
        wr(1, 16'h0003, 2'b01);
        rd(1, ctrl_full_exp, "ctrl_reset_en");
        step(); violation = 1'b1; spm_current_id = 16'h0004;
        step(); violation = 1'b0;
        expect_now(2, rst_req_exp, "reset_req_hi");
        step(); expect_now(2, 16'h0000, "reset_req_lo");
        rd(0, 16'h0009, "reset_req_logged");
        rd(5, 16'h0000, "out_of_range");

        // Mid-operation reset discards everything
        puc_rst = 1'b1;
        step(); step();
        puc_rst = 1'b0;
        rd(0, 16'h0000, "midrst_stat");
        rd(1, 16'h0000, "midrst_ctrl");
        rd(2, 16'h0000, "midrst_head_id");
        step(); expect_now(1, 16'h0000, "midrst_irq");

        step(); step();
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL leftover: %0d expectations not consumed, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
